// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: accepts operands in IDLE, adds one bit per clock LSB first, holds the result in DONE until taken.
// Latency WIDTH edges from accept to out_valid; result held stable under out_ready backpressure, new accepts only in IDLE.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic fa_sum;
  logic fa_cout;

  full_adder u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .c    (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    carry_d  = carry_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        carry_d  = fa_cout;
        sum_sh_d = {fa_sum, sum_sh_q[WIDTH-1:1]};
        if (cnt_q == LAST_BIT) begin
          // carry_q here is the carry into the sign bit
          sum_d   = {fa_sum, sum_sh_q[WIDTH-1:1]};
          cout_d  = fa_cout;
          ovf_d   = carry_q ^ fa_cout;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      carry_q  <= 1'b0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      carry_q  <= carry_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == BUSY);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// 1-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ c;
  assign cout = (a & b) | (a & c) | (b & c);

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8 with hand-computed results.
module tb_serial_adder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;
  logic       busy;

  int n_cmp;
  int n_bad;

  serial_adder #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_sum"}, sum, 0);
    check({tag, "_cout"}, cout, 0);
    check({tag, "_ovf"}, ovf, 0);
  endtask

  // Accept one operation, wait for the result, optionally stall, then consume it.
  task automatic run_op(input string tag, input logic [7:0] op_a, input logic [7:0] op_b,
                        input logic op_cin, input logic [7:0] exp_sum, input logic exp_cout,
                        input logic exp_ovf, input bit noisy, input int hold);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    a        = op_a;
    b        = op_b;
    cin      = op_cin;
    @(posedge clk); #1;
    check({tag, "_accept_busy"}, busy, 1);
    check({tag, "_accept_rdy"}, in_ready, 0);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      if (noisy) begin
        in_valid  = 1'($urandom_range(0, 1));
        a         = 8'($urandom);
        b         = 8'($urandom);
        cin       = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check({tag, "_latency"}, n, 8);
    check({tag, "_sum"}, sum, exp_sum);
    check({tag, "_cout"}, cout, exp_cout);
    check({tag, "_ovf"}, ovf, exp_ovf);
    check({tag, "_done_busy"}, busy, 0);
    check({tag, "_done_rdy"}, in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      a = 8'($urandom);
      b = 8'($urandom);
      @(posedge clk); #1;
      check({tag, "_hold_vld"}, out_valid, 1);
      check({tag, "_hold_sum"}, sum, exp_sum);
      check({tag, "_hold_cout"}, cout, exp_cout);
    end
    // Offer a new operand in the consume cycle; it must not be taken.
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a         = 8'hAA;
    b         = 8'h55;
    @(posedge clk); #1;
    check({tag, "_consumed_vld"}, out_valid, 0);
    check({tag, "_consumed_rdy"}, in_ready, 1);
    check({tag, "_consumed_busy"}, busy, 0);
    check({tag, "_idle_keep_sum"}, sum, exp_sum);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("basic",    8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 0);
    run_op("wrap",     8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0);
    run_op("posovf",   8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0, 0);
    run_op("negovf",   8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 0);
    run_op("backpres", 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, 1'b0, 5);
    run_op("noisy",    8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b1, 1'b1, 0);

    // Abort mid-operation: reset after four bits have been processed.
    @(negedge clk);
    in_valid = 1'b1;
    a        = 8'h55;
    b        = 8'h11;
    cin      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (2) @(posedge clk);
    #1;
    check("midrst_no_result", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("postrst",  8'h03, 8'h05, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
